// File: rtl/ternary_mvm_stream.sv
// ternary_mvm_stream: streaming ternary-weight matrix-vector multiply.
// A vector of IN_LEN signed elements arrives LANES per beat; every column
// accumulates weight(r,c)*x_r in parallel. Once the vector is complete, the
// OUT_LEN column sums are drained one word per handshake, each saturated or
// wrapped to BW bits.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input beat handshake (ready only while accumulating)
//   vec_in               LANES signed elements, lane l at [l*BW +: BW]
//   w                    ternary weights, weight(r,c) at [2*(r*OUT_LEN+c) +: 2]
//   clear                synchronous abort of the vector in flight
//   out_valid/out_ready  result word handshake (valid only while draining)
//   vec_out              current result word
//   out_last             high on column OUT_LEN-1
//   sat_flag             current word was clamped (SAT=1 only)
module ternary_mvm_stream #(
    parameter int unsigned IN_LEN  = 16,
    parameter int unsigned OUT_LEN = 8,
    parameter int unsigned BW      = 8,
    parameter int unsigned LANES   = 2,
    parameter int unsigned SAT     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*BW-1:0]           vec_in,
    input  logic [2*IN_LEN*OUT_LEN-1:0]   w,
    input  logic                          clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BW-1:0]                 vec_out,
    output logic                          out_last,
    output logic                          sat_flag
);

    localparam int unsigned BEATS   = IN_LEN / LANES;
    localparam int unsigned ACC_W   = BW + $clog2(IN_LEN) + 1;
    localparam int unsigned KW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned JW      = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam int unsigned BEAT_WW = 2 * LANES * OUT_LEN;

    localparam logic [KW-1:0] LAST_K = KW'(BEATS - 1);
    localparam logic [JW-1:0] LAST_J = JW'(OUT_LEN - 1);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (BW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [JW-1:0]           j_q, j_d;
    logic signed [ACC_W-1:0] acc_q [OUT_LEN];
    logic signed [ACC_W-1:0] acc_d [OUT_LEN];

    logic                    in_ready_d, out_valid_d, out_last_d, sat_flag_d;
    logic [BW-1:0]           vec_out_d;

    logic [BEAT_WW-1:0]      beat_w;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] lane;
    logic signed [ACC_W-1:0] sel;
    logic [1:0]              wsel;
    logic                    over, under;

    // State register, counters, accumulators and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            k_q       <= '0;
            j_q       <= '0;
            for (int c = 0; c < int'(OUT_LEN); c++) begin
                acc_q[c] <= '0;
            end
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            vec_out   <= '0;
            out_last  <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            j_q       <= j_d;
            for (int c = 0; c < int'(OUT_LEN); c++) begin
                acc_q[c] <= acc_d[c];
            end
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            vec_out   <= vec_out_d;
            out_last  <= out_last_d;
            sat_flag  <= sat_flag_d;
        end
    end

    // Next state, accumulate datapath and next output values
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        j_d         = j_q;
        for (int c = 0; c < int'(OUT_LEN); c++) begin
            acc_d[c] = acc_q[c];
        end
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        sat_flag_d  = 1'b0;
        vec_out_d   = '0;
        sum         = '0;
        lane        = '0;
        wsel        = 2'b00;
        sel         = '0;
        over        = 1'b0;
        under       = 1'b0;

        // Only the weight rows belonging to the current beat are used
        beat_w = BEAT_WW'(w >> (BEAT_WW * k_q));

        if (clear) begin
            state_d = ACCUM;
            k_d     = '0;
            j_d     = '0;
        end else if (state_q == ACCUM) begin
            if (in_valid) begin
                for (int c = 0; c < int'(OUT_LEN); c++) begin
                    // First beat restarts the sum, so no separate acc wipe is needed
                    sum = (k_q == '0) ? '0 : acc_q[c];
                    for (int l = 0; l < int'(LANES); l++) begin
                        lane = ACC_W'(signed'(vec_in[l*BW +: BW]));
                        wsel = beat_w[2*(l*int'(OUT_LEN)+c) +: 2];
                        if (wsel == 2'b01) begin
                            sum = sum + lane;
                        end else if (wsel == 2'b11) begin
                            sum = sum - lane;
                        end
                    end
                    acc_d[c] = sum;
                end
                if (k_q == LAST_K) begin
                    state_d = DRAIN;
                    k_d     = '0;
                    j_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
        end else begin
            if (out_ready) begin
                if (j_q == LAST_J) begin
                    state_d = ACCUM;
                    k_d     = '0;
                    j_d     = '0;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
        end

        // Output word for the column selected after this edge
        for (int c = 0; c < int'(OUT_LEN); c++) begin
            if (j_d == JW'(c)) begin
                sel = acc_d[c];
            end
        end
        over  = sel > MAX_V;
        under = sel < MIN_V;

        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DRAIN);
        if (state_d == DRAIN) begin
            out_last_d = (j_d == LAST_J);
            if (SAT != 0) begin
                sat_flag_d = over | under;
                vec_out_d  = over  ? MAX_V[BW-1:0] :
                             under ? MIN_V[BW-1:0] : sel[BW-1:0];
            end else begin
                vec_out_d  = sel[BW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ternary_mvm_stream.sv
// Directed bench for ternary_mvm_stream: a saturating and a wrapping instance
// share all stimulus; table rows hold vectors, weights and expected words.
module tb_ternary_mvm_stream;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready, w_in_ready;
    logic [15:0]  vec_in;
    logic [255:0] w;
    logic         clear;
    logic         out_valid, w_out_valid;
    logic         out_ready;
    logic [7:0]   vec_out, w_vec_out;
    logic         out_last, w_out_last;
    logic         sat_flag, w_sat_flag;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [255:0]     wv;
        logic [15:0][7:0] x;
        logic [7:0][7:0]  e1;   // expected words, SAT=1
        logic [7:0]       s1;   // expected sat_flag, SAT=1
        logic [7:0][7:0]  e0;   // expected words, SAT=0
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    ternary_mvm_stream #(.IN_LEN(16), .OUT_LEN(8), .BW(8), .LANES(2), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .vec_in(vec_in), .w(w), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .vec_out(vec_out), .out_last(out_last),
        .sat_flag(sat_flag)
    );

    ternary_mvm_stream #(.IN_LEN(16), .OUT_LEN(8), .BW(8), .LANES(2), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .vec_in(vec_in), .w(w), .clear(clear), .out_valid(w_out_valid),
        .out_ready(out_ready), .vec_out(w_vec_out), .out_last(w_out_last),
        .sat_flag(w_sat_flag)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input int idx, input int nb);
        for (int k = 0; k < nb; k++) begin
            in_valid = 1'b1;
            vec_in   = {tbl[idx].x[2*k+1], tbl[idx].x[2*k]};
            w        = tbl[idx].wv;
            tick();
        end
        in_valid = 1'b0;
        w        = '1;
        vec_in   = 16'($urandom);
    endtask

    task automatic drain(input int idx, input int first, input int stop);
        for (int c = first; c < stop; c++) begin
            out_ready = 1'b1;
            chk("out_valid", int'(out_valid), 1);
            chk("vec_out_sat", int'($signed(vec_out)), int'($signed(tbl[idx].e1[c])));
            chk("sat_flag", int'(sat_flag), int'(tbl[idx].s1[c]));
            chk("out_last", int'(out_last), (c == 7) ? 1 : 0);
            chk("vec_out_wrap", int'($signed(w_vec_out)), int'($signed(tbl[idx].e0[c])));
            chk("sat_flag_wrap", int'(w_sat_flag), 0);
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic run_full(input int idx);
        send_beats(idx, 8);
        chk("latency_out_valid", int'(out_valid), 1);
        chk("latency_in_ready", int'(in_ready), 0);
        drain(idx, 0, 8);
        chk("back_in_ready", int'(in_ready), 1);
        chk("back_out_valid", int'(out_valid), 0);
    endtask

    function automatic logic [255:0] wfill(input logic [1:0] v);
        logic [255:0] t;
        for (int i = 0; i < 128; i++) t[2*i +: 2] = v;
        return t;
    endfunction

    initial begin
        // Table: weights, inputs and hand-derived expected words
        tbl[0].wv = wfill(2'b01);
        for (int r = 0; r < 16; r++) tbl[0].x[r] = 8'd1;
        for (int c = 0; c < 8; c++) begin tbl[0].e1[c] = 8'd16; tbl[0].e0[c] = 8'd16; end
        tbl[0].s1 = 8'h00;

        tbl[1].wv = wfill(2'b01);
        for (int r = 0; r < 16; r++) tbl[1].x[r] = 8'd127;
        for (int c = 0; c < 8; c++) begin tbl[1].e1[c] = 8'd127; tbl[1].e0[c] = 8'hF0; end
        tbl[1].s1 = 8'hFF;

        tbl[2].wv = '0;
        for (int r = 0; r < 16; r++) begin
            tbl[2].wv[2*(r*8) +: 2] = (r % 2 == 0) ? 2'b01 : 2'b11;
            tbl[2].x[r] = 8'(r);
        end
        for (int c = 0; c < 8; c++) begin tbl[2].e1[c] = 8'd0; tbl[2].e0[c] = 8'd0; end
        tbl[2].e1[0] = 8'hF8;
        tbl[2].e0[0] = 8'hF8;
        tbl[2].s1 = 8'h00;

        tbl[3].wv = wfill(2'b11);
        for (int r = 0; r < 16; r++) tbl[3].x[r] = 8'h80;
        for (int c = 0; c < 8; c++) begin tbl[3].e1[c] = 8'd127; tbl[3].e0[c] = 8'd0; end
        tbl[3].s1 = 8'hFF;

        // Diagonal +1 with 2'b10 elsewhere: word c = x_c = 3c-20
        tbl[4].wv = wfill(2'b10);
        for (int r = 0; r < 16; r++) begin
            if (r < 8) tbl[4].wv[2*(r*8+r) +: 2] = 2'b01;
            tbl[4].x[r] = 8'(3*r - 20);
        end
        for (int c = 0; c < 8; c++) begin
            tbl[4].e1[c] = 8'(3*c - 20);
            tbl[4].e0[c] = 8'(3*c - 20);
        end
        tbl[4].s1 = 8'h00;

        // -1600: clamps to -128, wraps to 0xC0
        tbl[5].wv = wfill(2'b01);
        for (int r = 0; r < 16; r++) tbl[5].x[r] = 8'(-100);
        for (int c = 0; c < 8; c++) begin tbl[5].e1[c] = 8'h80; tbl[5].e0[c] = 8'hC0; end
        tbl[5].s1 = 8'hFF;

        rst_n = 1'b0; in_valid = 1'b0; vec_in = '0; w = '0; clear = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_vec_out", int'(vec_out), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_full(i);

        // Back-pressure on word 2 with in_valid asserted during drain
        send_beats(4, 8);
        drain(4, 0, 2);
        in_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            chk("stall_vec_out", int'($signed(vec_out)), -14);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_in_ready", int'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        drain(4, 2, 8);
        chk("stall_back_in_ready", int'(in_ready), 1);

        // Clear coincident with the 6th beat
        send_beats(0, 5);
        in_valid = 1'b1;
        vec_in   = 16'h0101;
        w        = tbl[0].wv;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("clear_out_valid", int'(out_valid), 0);
            chk("clear_in_ready", int'(in_ready), 1);
            tick();
        end
        run_full(4);

        // Clear during drain, coincident with an output handshake
        send_beats(1, 8);
        drain(1, 0, 2);
        clear = 1'b1;
        out_ready = 1'b1;
        tick();
        clear = 1'b0;
        out_ready = 1'b0;
        chk("dclear_out_valid", int'(out_valid), 0);
        chk("dclear_in_ready", int'(in_ready), 1);
        run_full(2);

        // Asynchronous reset on word 4 of the drain
        send_beats(3, 8);
        drain(3, 0, 4);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_vec_out", int'(vec_out), 0);
        chk("arst_sat_flag", int'(sat_flag), 0);
        chk("arst_out_last", int'(out_last), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_out_valid", int'(out_valid), 0);
        chk("post_rst_in_ready", int'(in_ready), 1);
        run_full(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
